// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, sync bundle type and image-select decode.
package vga_pkg;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic [7:0] IMG_W = 8'd160;
  localparam logic [7:0] IMG_H = 8'd120;

  typedef logic [14:0] image_addr_t;

  typedef struct packed {
    logic visible;
    logic hsync;
    logic vsync;
    logic frame_start;
  } sync_bundle_t;

  localparam sync_bundle_t SYNC_IDLE = '{visible: 1'b0, hsync: 1'b1, vsync: 1'b1, frame_start: 1'b0};

  typedef struct packed {
    logic       valid;
    logic [1:0] index;
  } image_pick_t;

  function automatic image_pick_t decode_select(input logic [3:0] sel);
    image_pick_t pick;
    pick = '0;
    case (sel)
      4'b0001: pick = '{valid: 1'b1, index: 2'd0};
      4'b0010: pick = '{valid: 1'b1, index: 2'd1};
      4'b0100: pick = '{valid: 1'b1, index: 2'd2};
      4'b1000: pick = '{valid: 1'b1, index: 2'd3};
      default: pick = '0;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/vga_delay_pipe.sv
// Fixed-depth shift register that keeps sync strobes aligned with ROM read latency.
module vga_delay_pipe
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  sync_bundle_t raw,
  output sync_bundle_t delayed
);

  // One stage always exists; with DEPTH=0 it is simply bypassed by the output mux.
  localparam int unsigned SLOTS = (DEPTH == 0) ? 1 : DEPTH;

  sync_bundle_t stage [SLOTS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SLOTS; i++) stage[i] <= SYNC_IDLE;
    end else begin
      stage[0] <= raw;
      for (int unsigned i = 1; i < SLOTS; i++) stage[i] <= stage[i-1];
    end
  end

  assign delayed = (DEPTH == 0) ? raw : stage[SLOTS-1];

endmodule

// File: rtl/vga_timer.sv
// 800x525 raster counters, texel ROM addressing, per-frame image latch and delayed sync strobes.
module vga_timer
  import vga_pkg::*;
#(
  parameter int unsigned PIPE_DELAY  = 2,
  parameter int unsigned SCALE_SHIFT = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  image_select_i,
  output logic [9:0]  position_x_o,
  output logic [9:0]  position_y_o,
  output logic [14:0] rom_addr_o,
  output logic [1:0]  image_o,
  output logic        visible_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        frame_start_o
);

  logic [9:0]   x, y;
  logic [1:0]   image;
  logic         x_last, y_last;
  logic [7:0]   col, row;
  image_addr_t  addr;
  image_pick_t  pick;
  sync_bundle_t raw, delayed;

  assign x_last = (x == H_TOTAL - 10'd1);
  assign y_last = (y == V_TOTAL - 10'd1);
  assign pick   = decode_select(image_select_i);

  // Image is only taken in the final cycle of a frame so a frame never mixes sources.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      x     <= '0;
      y     <= '0;
      image <= '0;
    end else begin
      x <= x_last ? '0 : x + 10'd1;
      if (x_last) y <= y_last ? '0 : y + 10'd1;
      if (x_last && y_last && pick.valid) image <= pick.index;
    end
  end

  always_comb begin
    raw.visible     = (x < H_VISIBLE) && (y < V_VISIBLE);
    raw.hsync       = !((x >= H_SYNC_START) && (x < H_SYNC_END));
    raw.vsync       = !((y >= V_SYNC_START) && (y < V_SYNC_END));
    raw.frame_start = (x == '0) && (y == '0);
  end

  // row*160 as two shifts; the texel bound also protects the ROM if SCALE_SHIFT changes.
  always_comb begin
    col  = 8'(x >> SCALE_SHIFT);
    row  = 8'(y >> SCALE_SHIFT);
    addr = '0;
    if (raw.visible && (col < IMG_W) && (row < IMG_H))
      addr = (image_addr_t'(row) << 7) + (image_addr_t'(row) << 5) + image_addr_t'(col);
  end

  vga_delay_pipe #(
    .DEPTH(PIPE_DELAY)
  ) u_pipe (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .raw    (raw),
    .delayed(delayed)
  );

  assign position_x_o  = x;
  assign position_y_o  = y;
  assign rom_addr_o    = addr;
  assign image_o       = image;
  assign visible_o     = delayed.visible;
  assign hsync_o       = delayed.hsync;
  assign vsync_o       = delayed.vsync;
  assign frame_start_o = delayed.frame_start;

endmodule

// File: tb/tb_vga_timer.sv
// Bench for vga_timer: PIPE_DELAY=2 and PIPE_DELAY=0 builds run in lockstep against a cycle-count model.
module tb_vga_timer;

  localparam int unsigned D     = 2;
  localparam longint      FRAME = 64'd420000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sel = '0;

  logic [9:0]  px, py, px0, py0;
  logic [14:0] addr, addr0;
  logic [1:0]  img, img0;
  logic        vis, hs, vs, fs, vis0, hs0, vs0, fs0;

  int          errors = 0;
  int          checks = 0;
  longint      t = 0;
  logic [1:0]  img_m = '0;

  vga_timer #(.PIPE_DELAY(D), .SCALE_SHIFT(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .image_select_i(sel),
    .position_x_o(px), .position_y_o(py), .rom_addr_o(addr), .image_o(img),
    .visible_o(vis), .hsync_o(hs), .vsync_o(vs), .frame_start_o(fs)
  );

  vga_timer #(.PIPE_DELAY(0), .SCALE_SHIFT(2)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .image_select_i(sel),
    .position_x_o(px0), .position_y_o(py0), .rom_addr_o(addr0), .image_o(img0),
    .visible_o(vis0), .hsync_o(hs0), .vsync_o(vs0), .frame_start_o(fs0)
  );

  always #5 clk = ~clk;

  initial begin
    #40000000;
    $display("FAIL watchdog: time limit expired, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Model: raster position is simply the cycle count since reset, folded into 800x525.
  function automatic int mx(input longint tt);
    return int'(tt % 800);
  endfunction

  function automatic int my(input longint tt);
    return int'((tt / 800) % 525);
  endfunction

  function automatic logic [3:0] ref_strobes(input int x, input int y);
    logic v, h, vv, f;
    v  = (x < 640) && (y < 480);
    h  = !(x >= 656 && x <= 751);
    vv = !(y >= 490 && y <= 491);
    f  = (x == 0) && (y == 0);
    return {v, h, vv, f};
  endfunction

  function automatic logic [3:0] ref_delayed(input longint tt, input int d);
    if (tt < longint'(d)) return 4'b0110;
    return ref_strobes(mx(tt - d), my(tt - d));
  endfunction

  function automatic int ref_addr(input int x, input int y);
    if (x < 640 && y < 480) return (y / 4) * 160 + (x / 4);
    return 0;
  endfunction

  task automatic tick(input logic [3:0] s, input logic r);
    sel   = s;
    rst_n = r;
    if (!r) begin
      t     = 0;
      img_m = '0;
    end else begin
      if (mx(t) == 799 && my(t) == 524 && $countones(s) == 1)
        for (int i = 0; i < 4; i++) if (s[i]) img_m = 2'(i);
      t++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(4'($urandom), 1'b0);
    tick(4'($urandom), 1'b0);
    checks++; if ({px, py} !== 20'd0) begin errors++; $display("FAIL reset_pos got x=%0d y=%0d want 0 0", px, py); end
    checks++; if (addr !== 15'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", addr); end
    checks++; if (img !== 2'd0) begin errors++; $display("FAIL reset_image got %0d want 0", img); end
    checks++; if ({vis, hs, vs, fs} !== 4'b0110) begin errors++; $display("FAIL reset_strobes got %b want 0110", {vis, hs, vs, fs}); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (fs !== (k == int'(D))) begin errors++; $display("FAIL frame_start_latency cycle=%0d got %b want %b", k, fs, (k == int'(D))); end
      tick(4'($urandom), 1'b1);
    end
  endtask

  task automatic test_frames();
    int     samples = 0;
    int     x, y;
    logic   ph, pv, pvis, want_hf, want_vis;
    longint last_hf = -1, last_hr = -1, last_vf = -1, last_vr = -1;
    logic [3:0] e, r, s;
    ph = hs; pv = vs; pvis = vis; want_hf = 1'b0; want_vis = 1'b0;
    for (longint n = 0; n < 4 * FRAME; n++) begin
      x = mx(t); y = my(t);
      e = ref_delayed(t, int'(D));
      r = ref_strobes(x, y);
      checks++; if ({px, py} !== {10'(x), 10'(y)}) begin errors++; $display("FAIL position t=%0d got %0d,%0d want %0d,%0d", t, px, py, x, y); end
      checks++; if (addr !== 15'(ref_addr(x, y))) begin errors++; $display("FAIL rom_addr x=%0d y=%0d got %0d want %0d", x, y, addr, ref_addr(x, y)); end
      checks++; if (img !== img_m) begin errors++; $display("FAIL image x=%0d y=%0d got %0d want %0d", x, y, img, img_m); end
      checks++; if ({vis, hs, vs, fs} !== e) begin errors++; $display("FAIL strobes_d2 x=%0d y=%0d got %b want %b", x, y, {vis, hs, vs, fs}, e); end
      checks++; if ({px0, py0, addr0, img0} !== {10'(x), 10'(y), 15'(ref_addr(x, y)), img_m}) begin
        errors++; $display("FAIL d0_position x=%0d y=%0d got %0d,%0d,%0d,%0d", x, y, px0, py0, addr0, img0); end
      checks++; if ({vis0, hs0, vs0, fs0} !== r) begin errors++; $display("FAIL strobes_d0 x=%0d y=%0d got %b want %b", x, y, {vis0, hs0, vs0, fs0}, r); end
      if (x == 639 && y == 0)   begin checks++; if (addr !== 15'd159)   begin errors++; $display("FAIL probe_639_0 got %0d want 159", addr); end end
      if (x == 4 && y == 4)     begin checks++; if (addr !== 15'd161)   begin errors++; $display("FAIL probe_4_4 got %0d want 161", addr); end end
      if (x == 639 && y == 479) begin checks++; if (addr !== 15'd19199) begin errors++; $display("FAIL probe_639_479 got %0d want 19199", addr); end end
      if (x == 640 && y == 0)   begin checks++; if ({addr, vis0} !== 16'd0) begin errors++; $display("FAIL probe_640_0 got addr=%0d vis=%b want 0 0", addr, vis0); end end
      if (ph && !hs) begin
        if (last_hr >= 0) begin checks++; if (t - last_hr != 704) begin errors++; $display("FAIL hsync_high got %0d want 704", t - last_hr); end end
        if (want_hf) begin checks++; want_hf = 1'b0; if (t - last_vr != 656) begin errors++; $display("FAIL vsync_to_hsync got %0d want 656", t - last_vr); end end
        last_hf = t;
      end
      if (!ph && hs) begin
        if (last_hf >= 0) begin checks++; if (t - last_hf != 96) begin errors++; $display("FAIL hsync_low got %0d want 96", t - last_hf); end end
        last_hr = t;
      end
      if (pv && !vs) begin
        if (last_vr >= 0) begin checks++; if (t - last_vr != 418400) begin errors++; $display("FAIL vsync_high got %0d want 418400", t - last_vr); end end
        last_vf = t;
      end
      if (!pv && vs) begin
        if (last_vf >= 0) begin checks++; if (t - last_vf != 1600) begin errors++; $display("FAIL vsync_low got %0d want 1600", t - last_vf); end end
        last_vr = t; want_hf = 1'b1; want_vis = 1'b1;
      end
      if (!pvis && vis && want_vis) begin
        checks++; want_vis = 1'b0;
        if (t - last_vr != 26400) begin errors++; $display("FAIL vsync_to_visible got %0d want 26400", t - last_vr); end
      end
      ph = hs; pv = vs; pvis = vis;
      if (samples >= 3 && x == 20) break;
      if (x == 799 && y == 524) begin
        s = (samples == 0) ? 4'b0100 : (samples == 1) ? 4'b0110 : 4'b1000;
        samples++;
      end else begin
        s = 4'($urandom);
      end
      tick(s, 1'b1);
      if (errors > 50) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
    checks++;
    if (samples != 3) begin errors++; $display("FAIL frame_budget got samples=%0d want 3", samples); end
    checks++;
    if (img !== 2'd3) begin errors++; $display("FAIL image_final got %0d want 3", img); end
  endtask

  task automatic test_mid_reset();
    logic found = 1'b0;
    for (longint n = 0; n < FRAME; n++) begin
      if (mx(t) == 300 && my(t) == 200) begin found = 1'b1; break; end
      tick(4'($urandom), 1'b1);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_reset_reach got no x=300 y=200 want reached"); end
    checks++;
    if ({vis, hs, vs, fs, img} !== {ref_delayed(t, int'(D)), img_m}) begin
      errors++; $display("FAIL pre_reset got %b/%0d want %b/%0d", {vis, hs, vs, fs}, img, ref_delayed(t, int'(D)), img_m); end
    tick(4'($urandom), 1'b0);
    checks++; if ({px, py} !== 20'd0) begin errors++; $display("FAIL mid_reset_pos got %0d,%0d want 0,0", px, py); end
    checks++; if (img !== 2'd0) begin errors++; $display("FAIL mid_reset_image got %0d want 0", img); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({vis, hs, vs, fs} !== ref_delayed(t, int'(D))) begin
        errors++; $display("FAIL refill cycle=%0d got %b want %b", k, {vis, hs, vs, fs}, ref_delayed(t, int'(D))); end
      tick(4'($urandom), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timer.md
Name: vga_timer

Overview:
- Generates 640x480 @ 60 Hz VGA timing (25.175 MHz pixel clock, 800x525 total) for the screensaver top level.
- Outputs undelayed raster position and a 160x120 image-ROM address (each image texel covers 4x4 pixels) for the downstream pixel fetch.
- Outputs sync/visible strobes delayed by PIPE_DELAY so they stay aligned with ROM read latency.
- Latches the one-hot image selection once per frame so the selection never changes mid-frame.

Parameters:
- PIPE_DELAY, 2, cycles between address/position outputs and the matching sync/visible outputs (0..4).
- SCALE_SHIFT, 2, log2 of pixel-to-texel scale (texel = position >> SCALE_SHIFT).

Ports:
- clk_i  in  1  pixel clock, 25.175 MHz
- rst_ni  in  1  synchronous active-low reset
- image_select_i  in  4  one-hot image request; non-one-hot means keep the current image
- position_x_o  out  10  horizontal counter 0..799, undelayed
- position_y_o  out  10  vertical counter 0..524, undelayed
- rom_addr_o  out  15  (y>>2)*160 + (x>>2), valid when x<640 and y<480, else 0
- image_o  out  2  index of the latched image, aligned with rom_addr_o
- visible_o  out  1  delayed: pixel is in the active area
- hsync_o  out  1  delayed, active-low
- vsync_o  out  1  delayed, active-low
- frame_start_o  out  1  delayed one-cycle pulse at x=0, y=0

Behaviour:
- Reset is synchronous and active-low; there is one clock, clk_i.
- Reset values:
  - x=0, y=0, rom_addr_o=0, image_o=0.
  - Every delay-pipe stage resets to the inactive values: visible 0, hsync 1, vsync 1, frame_start 0.
- Reset asserted mid-frame: on the next edge, counters return to (0,0) and all pipe stages go inactive. No partial-frame state survives.
- Horizontal counter:
  - x increments each cycle and wraps 799→0.
  - When x wraps, y increments; y wraps 524→0.
- Raw strobes, computed from (x,y) in the same cycle:
  - visible = x<640 && y<480.
  - hsync low for 656≤x≤751 (96 cycles).
  - vsync low for 490≤y≤491 (1600 cycles). vsync edges coincide with x=0.
  - Resulting timing: vsync high for 418400 cycles; 656 cycles from vsync rise to the next hsync fall; 26400 cycles from vsync rise to the first visible pixel.
- Delay pipe:
  - The raw strobes pass through a PIPE_DELAY-deep shift register, producing the *_o outputs.
  - PIPE_DELAY=0 means a combinational pass-through.
- Address arithmetic:
  - col = x[9:2], row = y[9:2].
  - rom_addr_o = (row<<7) + (row<<5) + col, computed combinationally from the counters.
  - Outside the active area, rom_addr_o is forced to 0.
  - Maximum address is 19199.
- Image latch:
  - Sampled only in the cycle x=799, y=524 (the last cycle before the frame).
  - If image_select_i is one-hot, image_o ← its bit index. Otherwise image_o holds.
  - image_o is therefore constant for all 480 visible lines.
  - A change on image_select_i at any other cycle has no effect until the next sample point.
- Following the first release from reset:
  - Counters start at (0,0), so the first frame begins immediately.
  - frame_start_o pulses PIPE_DELAY cycles later.

Decomposition:
- Package vga_pkg holds:
  - H_VISIBLE=640, H_FRONT=16, H_SYNC=96, H_BACK=48, H_TOTAL=800.
  - V_VISIBLE=480, V_FRONT=10, V_SYNC=2, V_BACK=33, V_TOTAL=525.
  - IMG_W=160, IMG_H=120.
  - typedef image_addr_t (15 bits).
  - typedef sync_bundle_t struct {visible, hsync, vsync, frame_start}.
- Sub-module vga_delay_pipe: parameterised DEPTH shift register of sync_bundle_t, with per-stage reset to inactive values. The top instantiates it once.

Test Plan:
- Reset held 2 cycles, then released, PIPE_DELAY=2 → frame_start_o high exactly 2 cycles after release. hsync_o low pulses are 96 cycles wide with 704 cycles high between them.
- Run 3 frames → vsync_o low 1600 cycles and high 418400 cycles. From vsync_o rise: 656 cycles to hsync_o fall, 26400 cycles to visible_o rise.
- Probe addresses:
  - x=0, y=0 → rom_addr_o=0.
  - x=639, y=0 → 159.
  - x=4, y=4 → 161.
  - x=639, y=479 → 19199.
  - x=640, y=0 → 0 and visible low.
- Image latch:
  - image_select_i=4'b0100 driven mid-frame → image_o stays 0 until x=799, y=524, then becomes 2.
  - Next frame image_select_i=4'b0000 and 4'b0110 → image_o stays 2.
  - Then 4'b1000 → image_o becomes 3 at the next sample point.
- Reset asserted at x=300, y=200 for 1 cycle → next cycle position=(0,0), image_o=0, hsync_o/vsync_o=1, visible_o=0 until the pipe refills.
- PIPE_DELAY=0 build → visible_o, hsync_o and vsync_o match the raw decode in the same cycle as position_x_o/position_y_o.
